plic_target_ctrl: RTL and testbench

PLIC_TARGET_CTRL -- requirements
Module: plic_target_ctrl

---
 rtl/plic_pkg.sv | 12 +
 rtl/plic_priority_index.sv | 53 +++++
 rtl/plic_target_ctrl.sv | 157 +++++++++++++++
 tb/tb_plic_target_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared PLIC target definitions: controller states and the post-claim flush length.
package plic_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } plic_state_e;

  localparam int unsigned FLUSH_LEN  = 2;
  localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_LEN - 1);

endpackage

// File: rtl/plic_priority_index.sv
// Recursive max-priority tree; on a tie the lower half (lower IDs) wins.
module plic_priority_index #(
  parameter int N  = 16,
  parameter int PW = 3,
  parameter int IW = 5
) (
  input  logic [N-1:0][PW-1:0] prio_i,
  input  logic [N-1:0][IW-1:0] idx_i,
  output logic [PW-1:0]        prio_o,
  output logic [IW-1:0]        idx_o
);

  generate
    if (N == 1) begin : g_leaf
      assign prio_o = prio_i[0];
      assign idx_o  = idx_i[0];
    end else begin : g_node
      localparam int LO = N / 2;
      localparam int HI = N - LO;

      logic [PW-1:0] lo_prio;
      logic [IW-1:0] lo_idx;
      logic [PW-1:0] hi_prio;
      logic [IW-1:0] hi_idx;

      plic_priority_index #(.N(LO), .PW(PW), .IW(IW)) u_lo (
        .prio_i (prio_i[LO-1:0]),
        .idx_i  (idx_i[LO-1:0]),
        .prio_o (lo_prio),
        .idx_o  (lo_idx)
      );

      plic_priority_index #(.N(HI), .PW(PW), .IW(IW)) u_hi (
        .prio_i (prio_i[N-1:LO]),
        .idx_i  (idx_i[N-1:LO]),
        .prio_o (hi_prio),
        .idx_o  (hi_idx)
      );

      // Pick the stronger half, preferring the lower-ID half on equality.
      always_comb begin
        if (lo_prio >= hi_prio) begin
          prio_o = lo_prio;
          idx_o  = lo_idx;
        end else begin
          prio_o = hi_prio;
          idx_o  = hi_idx;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/plic_target_ctrl.sv
// PLIC target: eligible-source search, threshold compare, claim/complete handshake.
module plic_target_ctrl
  import plic_pkg::*;
#(
  parameter int SOURCES       = 16,
  parameter int PRIORITIES    = 7,
  parameter int SOURCES_BITS  = 5,
  parameter int PRIORITY_BITS = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [SOURCES-1:0]                     pending_i,
  input  logic [SOURCES-1:0]                     enable_i,
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0]  priority_i,
  input  logic [PRIORITY_BITS-1:0]               threshold_i,
  input  logic                                   claim_i,
  input  logic                                   complete_i,
  input  logic [SOURCES_BITS-1:0]                complete_id_i,
  output logic                                   irq_o,
  output logic [SOURCES_BITS-1:0]                id_o,
  output logic [SOURCES-1:0]                     claim_o,
  output logic [SOURCES-1:0]                     complete_o
);

  plic_state_e                              state_q, state_d;
  logic [1:0]                               flush_cnt_q, flush_cnt_d;
  logic [PRIORITY_BITS-1:0]                 best_prio_q, best_prio_d;
  logic [SOURCES_BITS-1:0]                  best_id_q, best_id_d;
  logic [PRIORITY_BITS-1:0]                 threshold_q;
  logic                                     irq_q, irq_d;
  logic [SOURCES-1:0]                       claim_q, claim_d;
  logic [SOURCES-1:0]                       complete_q, complete_d;

  logic [SOURCES-1:0][PRIORITY_BITS-1:0]    prio_masked;
  logic [SOURCES-1:0][SOURCES_BITS-1:0]     src_idx;
  logic [PRIORITY_BITS-1:0]                 win_prio;
  logic [SOURCES_BITS-1:0]                  win_id;
  logic                                     above_thr;
  logic                                     grant;

  // Non-eligible sources compete with priority 0 so they can never win.
  always_comb begin
    for (int n = 0; n < SOURCES; n++) begin
      src_idx[n] = SOURCES_BITS'(n + 1);
      if (pending_i[n] && enable_i[n] && (priority_i[n] != '0)) begin
        prio_masked[n] = priority_i[n];
      end else begin
        prio_masked[n] = '0;
      end
    end
  end

  plic_priority_index #(.N(SOURCES), .PW(PRIORITY_BITS), .IW(SOURCES_BITS)) u_search (
    .prio_i (prio_masked),
    .idx_i  (src_idx),
    .prio_o (win_prio),
    .idx_o  (win_id)
  );

  // Registered search result; nothing eligible reports ID 0.
  always_comb begin
    best_prio_d = win_prio;
    if (win_prio == '0) begin
      best_id_d = '0;
    end else begin
      best_id_d = win_id;
    end
  end

  // A threshold at or beyond the top level masks everything.
  assign above_thr = (int'(threshold_q) < PRIORITIES) && (best_prio_q > threshold_q);
  assign grant     = claim_i && (state_q == RUN) && above_thr;

  // Claim read data is combinational and only valid during the strobe.
  always_comb begin
    if (grant) begin
      id_o = best_id_q;
    end else begin
      id_o = '0;
    end
  end

  // Claim freezes the target for a fixed flush window; claims inside it are ignored.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (claim_i) begin
          state_d     = FLUSH;
          flush_cnt_d = 2'd0;
        end else begin
          flush_cnt_d = 2'd0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = RUN;
          flush_cnt_d = 2'd0;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = 2'd0;
      end
    endcase
  end

  // Interrupt and one-hot gateway pulses for the next cycle.
  always_comb begin
    irq_d      = (state_d == RUN) && above_thr;
    claim_d    = '0;
    complete_d = '0;
    for (int n = 0; n < SOURCES; n++) begin
      if (grant && (best_id_q == SOURCES_BITS'(n + 1))) begin
        claim_d[n] = 1'b1;
      end else begin
        claim_d[n] = 1'b0;
      end
      if (complete_i && enable_i[n] && (complete_id_i == SOURCES_BITS'(n + 1))) begin
        complete_d[n] = 1'b1;
      end else begin
        complete_d[n] = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
      best_prio_q <= '0;
      best_id_q   <= '0;
      threshold_q <= '0;
      irq_q       <= 1'b0;
      claim_q     <= '0;
      complete_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      best_prio_q <= best_prio_d;
      best_id_q   <= best_id_d;
      threshold_q <= threshold_i;
      irq_q       <= irq_d;
      claim_q     <= claim_d;
      complete_q  <= complete_d;
    end
  end

  assign irq_o      = irq_q;
  assign claim_o    = claim_q;
  assign complete_o = complete_q;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Directed plus randomized checks of plic_target_ctrl against a cycle-level reference model.
module tb_plic_target_ctrl;

  localparam int S  = 8;
  localparam int NP = 7;
  localparam int SB = 4;
  localparam int PB = 3;
  localparam int FL = 2;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [S-1:0]           pending_i;
  logic [S-1:0]           enable_i;
  logic [S-1:0][PB-1:0]   priority_i;
  logic [PB-1:0]          threshold_i;
  logic                   claim_i;
  logic                   complete_i;
  logic [SB-1:0]          complete_id_i;
  logic                   irq_o;
  logic [SB-1:0]          id_o;
  logic [S-1:0]           claim_o;
  logic [S-1:0]           complete_o;

  always #5 clk = ~clk;

  plic_target_ctrl #(
    .SOURCES(S), .PRIORITIES(NP), .SOURCES_BITS(SB), .PRIORITY_BITS(PB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .pending_i(pending_i), .enable_i(enable_i),
    .priority_i(priority_i), .threshold_i(threshold_i), .claim_i(claim_i),
    .complete_i(complete_i), .complete_id_i(complete_id_i), .irq_o(irq_o),
    .id_o(id_o), .claim_o(claim_o), .complete_o(complete_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (values visible on the outputs this cycle).
  bit       m_run  = 1'b1;
  int       m_left = 0;
  int       m_bp   = 0;
  int       m_bid  = 0;
  int       m_thr  = 0;
  bit       m_irq  = 1'b0;
  int       m_claim = 0;
  int       m_comp  = 0;

  logic [31:0] s_irq, s_id, s_claim, s_comp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Highest priority wins; scanning upward with strict > keeps the lowest ID on ties.
  task automatic search(output int bp, output int bid);
    bp  = 0;
    bid = 0;
    for (int n = 0; n < S; n++) begin
      if (pending_i[n] && enable_i[n] && int'(priority_i[n]) > bp) begin
        bp  = int'(priority_i[n]);
        bid = n + 1;
      end
    end
  endtask

  task automatic cycle();
    int  eid, nl, nbp, nbid, ncl, ncp, cid;
    bit  nr, nirq;
    bit  live;
    @(negedge clk);
    live = (m_thr < NP) && (m_bp > m_thr);
    eid  = (claim_i && m_run && live) ? m_bid : 0;
    s_irq   = 32'(irq_o);
    s_id    = 32'(id_o);
    s_claim = 32'(claim_o);
    s_comp  = 32'(complete_o);
    check("irq_o",      s_irq,   32'(m_irq));
    check("claim_o",    s_claim, 32'(m_claim));
    check("complete_o", s_comp,  32'(m_comp));
    check("id_o",       s_id,    32'(eid));
    nr = m_run;
    nl = m_left;
    if (m_run) begin
      if (claim_i) begin
        nr = 1'b0;
        nl = FL;
      end
    end else begin
      nl = m_left - 1;
      if (nl == 0) nr = 1'b1;
    end
    nirq = nr && live;
    ncl  = (eid != 0) ? (1 << (eid - 1)) : 0;
    cid  = int'(complete_id_i);
    ncp  = (complete_i && cid >= 1 && cid <= S && enable_i[cid-1]) ? (1 << (cid - 1)) : 0;
    search(nbp, nbid);
    @(posedge clk);
    if (rst_i) begin
      m_run = 1'b1; m_left = 0; m_bp = 0; m_bid = 0; m_thr = 0;
      m_irq = 1'b0; m_claim = 0; m_comp = 0;
    end else begin
      m_run = nr; m_left = nl; m_bp = nbp; m_bid = nbid; m_thr = int'(threshold_i);
      m_irq = nirq; m_claim = ncl; m_comp = ncp;
    end
    #1;
  endtask

  task automatic setup_src3();
    pending_i     = 8'h08;
    enable_i      = 8'h08;
    priority_i    = '0;
    priority_i[3] = 3'd5;
    threshold_i   = 3'd2;
  endtask

  initial begin
    rst_i = 1'b1; pending_i = '0; enable_i = '0; priority_i = '0; threshold_i = '0;
    claim_i = 1'b0; complete_i = 1'b0; complete_id_i = '0;
    cycle(); cycle();
    check("reset_irq", s_irq, 32'd0);
    rst_i = 1'b0;

    // Single source above threshold, then claim and flush window.
    setup_src3();
    cycle(); cycle(); cycle();
    check("src3_irq_lat2", s_irq, 32'd1);
    claim_i = 1'b1; cycle();
    check("src3_id", s_id, 32'd4);
    claim_i = 1'b0; cycle();
    check("src3_claim_pulse", s_claim, 32'h08);
    check("src3_irq_flush1", s_irq, 32'd0);
    cycle();
    check("src3_irq_flush2", s_irq, 32'd0);
    cycle();
    check("src3_irq_back", s_irq, 32'd1);

    // Equal priorities: lowest ID wins.
    pending_i = 8'h42; enable_i = 8'h42; priority_i = '0;
    priority_i[1] = 3'd4; priority_i[6] = 3'd4; threshold_i = 3'd0;
    cycle(); cycle();
    claim_i = 1'b1; cycle();
    check("tie_id", s_id, 32'd2);
    claim_i = 1'b0; cycle(); cycle(); cycle();

    // Priority equal to threshold never interrupts.
    pending_i = 8'h01; enable_i = 8'h01; priority_i = '0;
    priority_i[0] = 3'd3; threshold_i = 3'd3;
    cycle(); cycle(); cycle();
    check("thr_eq_irq", s_irq, 32'd0);
    claim_i = 1'b1; cycle();
    check("thr_eq_id", s_id, 32'd0);
    claim_i = 1'b0; cycle();
    check("thr_eq_claim", s_claim, 32'd0);
    cycle(); cycle();

    // Maximum threshold masks even the top priority.
    priority_i[0] = 3'd7; threshold_i = 3'd7;
    cycle(); cycle(); cycle();
    check("thr_max_irq", s_irq, 32'd0);

    // Back-to-back claims: second falls inside the flush window.
    setup_src3();
    cycle(); cycle(); cycle();
    claim_i = 1'b1; cycle();
    check("b2b_id1", s_id, 32'd4);
    cycle();
    check("b2b_id2", s_id, 32'd0);
    check("b2b_pulse1", s_claim, 32'h08);
    claim_i = 1'b0; cycle();
    check("b2b_no_pulse2", s_claim, 32'd0);
    cycle(); cycle();

    // Completion filtering.
    enable_i = 8'h10;
    complete_i = 1'b1; complete_id_i = 4'd5; cycle();
    complete_i = 1'b0; cycle();
    check("cmp_id5", s_comp, 32'h10);
    complete_i = 1'b1; complete_id_i = 4'd0; cycle();
    complete_i = 1'b0; cycle();
    check("cmp_id0", s_comp, 32'd0);
    complete_i = 1'b1; complete_id_i = 4'd9; cycle();
    complete_i = 1'b0; cycle();
    check("cmp_id9", s_comp, 32'd0);
    enable_i = 8'h00;
    complete_i = 1'b1; complete_id_i = 4'd5; cycle();
    complete_i = 1'b0; cycle();
    check("cmp_id5_dis", s_comp, 32'd0);

    // Simultaneous claim and complete of the same source.
    setup_src3();
    cycle(); cycle(); cycle();
    claim_i = 1'b1; complete_i = 1'b1; complete_id_i = 4'd4; cycle();
    claim_i = 1'b0; complete_i = 1'b0; cycle();
    check("both_claim", s_claim, 32'h08);
    check("both_comp",  s_comp,  32'h08);
    cycle(); cycle();

    // Reset in the first flush cycle drops the pulse and returns to RUN.
    cycle();
    claim_i = 1'b1; cycle();
    claim_i = 1'b0; rst_i = 1'b1; cycle();
    rst_i = 1'b0; cycle();
    check("rst_flush_irq",   s_irq,   32'd0);
    check("rst_flush_claim", s_claim, 32'd0);
    check("rst_flush_comp",  s_comp,  32'd0);
    cycle();
    check("rst_rel_irq1", s_irq, 32'd0);
    cycle();
    check("rst_rel_irq2", s_irq, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_i         = ($urandom_range(0, 63) == 0);
      pending_i     = 8'($urandom);
      enable_i      = 8'($urandom);
      priority_i    = 24'($urandom);
      threshold_i   = 3'($urandom_range(0, 7));
      claim_i       = ($urandom_range(0, 3) == 0);
      complete_i    = ($urandom_range(0, 3) == 0);
      complete_id_i = 4'($urandom_range(0, 10));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
